// File: rtl/brsf_uart_pkg.sv
// brsf_uart_pkg - shared definitions for the brsf UART blocks.
//
// Contents:
//   uart_state_t  transmitter FSM state encoding. PAR keeps its code even in
//                 builds where parity is compiled out, so encodings never shift.
//   MARK / SPACE  serial line levels (idle / start).
//   frame_clocks  frame length in Clk cycles for a given configuration.

package brsf_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5
  } uart_state_t;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Start bit + data bits + optional parity bit + stop bits, each baud_div clocks.
  function automatic int frame_clocks(input int width, input int baud_div,
                                      input int stop_bits, input int parity_bits);
    return (1 + width + parity_bits + stop_bits) * baud_div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen - bit-period down-counter shared by the UART transmitter and
// the planned receiver.
//
// Parameters:
//   pBaudDiv  Clk cycles per serial bit (2..65535)
// Ports:
//   Clk   in   system clock, rising edge
//   Rst   in   synchronous active-high reset, clears the count to 0
//   load  in   restart the bit period (count <= pBaudDiv-1)
//   tick  out  high in the last cycle of each bit period (count == 0)
//
// The counter reloads itself on every tick, so once loaded each bit lasts
// exactly pBaudDiv clocks.

module uart_baud_gen #(
  parameter int pBaudDiv = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(pBaudDiv - 1);

  logic [15:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/brsf_uart_tx.sv
// brsf_uart_tx - asynchronous serial transmitter fed from the read port of the
// synchronous block-RAM FIFO. Emits LSB-first start/data/[parity]/stop frames.
//
// Build option:
//   BRSF_UART_TX_PARITY_EN  when defined, a parity bit (sense chosen by Odd)
//                           follows the data bits; otherwise Odd is unused.
// Parameters:
//   pWidth     data bits per character (equals FIFO data width)
//   pBaudDiv   Clk cycles per serial bit (2..65535)
//   pStopBits  stop bits, 1 or 2
// Ports:
//   Clk     in   system clock, rising edge
//   Rst     in   synchronous active-high reset
//   EF      in   FIFO empty flag
//   RE      out  FIFO read enable, single-cycle pulse from IDLE
//   ACK     in   FIFO read acknowledge, one cycle after RE
//   DI      in   FIFO data, captured when ACK=1
//   nCTS    in   clear-to-send, active-low, only consulted in IDLE
//   Odd     in   parity sense (1 = odd, 0 = even)
//   TxD     out  serial line, 1 = mark/idle
//   Busy    out  high from data capture through the last stop bit
//   TxDone  out  one-cycle pulse after the last stop bit

module brsf_uart_tx #(
  parameter int pWidth    = 8,
  parameter int pBaudDiv  = 16,
  parameter int pStopBits = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EF,
  output logic              RE,
  input  logic              ACK,
  input  logic [pWidth-1:0] DI,
  input  logic              nCTS,
  input  logic              Odd,
  output logic              TxD,
  output logic              Busy,
  output logic              TxDone
);

  import brsf_uart_pkg::*;

  localparam int BW = (pWidth > 1) ? $clog2(pWidth) : 1;
  localparam logic [BW-1:0] LASTBIT  = BW'(pWidth - 1);
  localparam logic          STOPLAST = 1'(pStopBits - 1);

  uart_state_t       state, state_d;
  logic [pWidth-1:0] shreg, shreg_d;
  logic [BW-1:0]     bitcnt, bitcnt_d;
  logic              stopcnt, stopcnt_d;
  logic              txd_d, busy_d, done_d;
  logic              load, tick;

`ifdef BRSF_UART_TX_PARITY_EN
  logic par, par_d;
`else
  logic oddunused;
  assign oddunused = Odd;
`endif

  uart_baud_gen #(
    .pBaudDiv(pBaudDiv)
  ) u_baud (
    .Clk (Clk),
    .Rst (Rst),
    .load(load),
    .tick(tick)
  );

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bitcnt_d  = bitcnt;
    stopcnt_d = stopcnt;
    txd_d     = TxD;
    busy_d    = Busy;
    done_d    = 1'b0;
    load      = 1'b0;
    RE        = 1'b0;
`ifdef BRSF_UART_TX_PARITY_EN
    par_d     = par;
`endif
    case (state)
      S_IDLE: begin
        RE = ~Rst & ~EF & ~nCTS;
        if (RE) state_d = S_WAIT;
      end
      S_WAIT: begin
        // ACK=0 here means the FIFO was cleared under us: drop the request.
        if (ACK) begin
          shreg_d   = DI;
          load      = 1'b1;
          bitcnt_d  = '0;
          stopcnt_d = 1'b0;
          busy_d    = 1'b1;
          txd_d     = SPACE;
`ifdef BRSF_UART_TX_PARITY_EN
          par_d     = (^DI) ^ Odd;
`endif
          state_d   = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick) begin
          txd_d   = shreg[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d  = shreg >> 1;
          bitcnt_d = bitcnt + 1'b1;
          if (bitcnt == LASTBIT) begin
`ifdef BRSF_UART_TX_PARITY_EN
            txd_d   = par;
            state_d = S_PAR;
`else
            txd_d   = MARK;
            state_d = S_STOP;
`endif
          end else begin
            txd_d = shreg_d[0];
          end
        end
      end
`ifdef BRSF_UART_TX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          txd_d   = MARK;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (stopcnt == STOPLAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stopcnt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      TxD     <= MARK;
      Busy    <= 1'b0;
      TxDone  <= 1'b0;
`ifdef BRSF_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bitcnt  <= bitcnt_d;
      stopcnt <= stopcnt_d;
      TxD     <= txd_d;
      Busy    <= busy_d;
      TxDone  <= done_d;
`ifdef BRSF_UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

endmodule
